// File: rtl/game_pkg.sv
// game_pkg: shared vertical-state enum, winner codes and input bit indices for the arena core.
package game_pkg;
  typedef enum logic [1:0] {GROUND, RISE, FALL} vstate_t;
  localparam logic [1:0] WIN_NONE = 2'b00, WIN_P1 = 2'b01, WIN_P2 = 2'b10, WIN_DRAW = 2'b11;
  localparam int IN_CENTER = 0, IN_LEFT = 1, IN_RIGHT = 2, IN_UP = 3, IN_DOWN = 4, IN_ATK = 5, IN_SHIELD = 6;
endpackage

// File: rtl/fighter_motion.sv
// fighter_motion: one fighter's jump FSM, attack edge/cooldown and proposed horizontal position.
module fighter_motion import game_pkg::*; #(
  parameter int SCREEN_W     = 1024,
  parameter int CHAR_W       = 128,
  parameter int GROUND_Y     = 300,
  parameter int STEP         = 1,
  parameter int JUMP_H       = 96,
  parameter int ATK_COOLDOWN = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_step,
  input  logic       i_restart,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_up,
  input  logic       i_atk,
  input  logic [9:0] i_x,
  output logic [9:0] o_px,
  output logic [9:0] o_y,
  output logic       o_fire,
  output logic       o_attacking
);
  localparam int XMAX = SCREEN_W - CHAR_W;
  localparam int CW = $clog2(ATK_COOLDOWN + 1);
  vstate_t r_vs, w_vs_nx;
  logic [9:0] r_y, w_y_nx;
  logic [CW-1:0] r_cd, w_cd_nx;
  logic r_prev;
  assign o_px = i_left ? (i_x < 10'(STEP) ? 10'd0 : i_x - 10'(STEP)) :
                i_right ? (32'(i_x) + STEP > XMAX ? 10'(XMAX) : i_x + 10'(STEP)) : i_x;
  assign o_fire = i_atk & ~r_prev & (r_cd == '0);
  assign o_y = r_y;
  assign w_cd_nx = o_fire ? CW'(ATK_COOLDOWN) : (r_cd == '0 ? '0 : r_cd - 1'b1);
  always_comb begin
    w_vs_nx = r_vs;
    w_y_nx = r_y;
    case (r_vs)
      GROUND: if (i_up) w_vs_nx = RISE;
      RISE: begin
        w_y_nx = r_y - 10'(STEP);
        if (w_y_nx == 10'(GROUND_Y - JUMP_H)) w_vs_nx = FALL;
      end
      FALL: begin
        w_y_nx = r_y + 10'(STEP);
        if (w_y_nx == 10'(GROUND_Y)) w_vs_nx = GROUND;
      end
      default: w_vs_nx = GROUND;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs <= GROUND;
      r_y <= 10'(GROUND_Y);
      r_cd <= '0;
      r_prev <= 1'b0;
      o_attacking <= 1'b0;
    end else if (i_restart) begin
      r_vs <= GROUND;
      r_y <= 10'(GROUND_Y);
      r_cd <= '0;
      r_prev <= 1'b0;
      o_attacking <= 1'b0;
    end else if (i_step) begin
      r_vs <= w_vs_nx;
      r_y <= w_y_nx;
      r_cd <= w_cd_nx;
      r_prev <= i_atk;
      o_attacking <= w_cd_nx != '0;
    end
  end
endmodule

// File: rtl/fight_arena_core.sv
// fight_arena_core: two-fighter arena with tick enable, overlap arbitration, hit resolution and match state.
module fight_arena_core import game_pkg::*; #(
  parameter int TICK_DIV     = 800_000,
  parameter int SCREEN_W     = 1024,
  parameter int CHAR_W       = 128,
  parameter int CHAR_H       = 128,
  parameter int GROUND_Y     = 300,
  parameter int P1_START_X   = 200,
  parameter int P2_START_X   = 600,
  parameter int STEP         = 1,
  parameter int JUMP_H       = 96,
  parameter int REACH        = 16,
  parameter int MAX_HEALTH   = 15,
  parameter int MAX_SHIELD   = 15,
  parameter int ATK_DMG      = 3,
  parameter int ATK_COOLDOWN = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_p1_inputs,
  input  logic [6:0] i_p2_inputs,
  output logic [9:0] o_p1_x,
  output logic [9:0] o_p1_y,
  output logic [9:0] o_p2_x,
  output logic [9:0] o_p2_y,
  output logic [7:0] o_p1_health,
  output logic [7:0] o_p1_shield,
  output logic [7:0] o_p2_health,
  output logic [7:0] o_p2_shield,
  output logic       o_p1_attacking,
  output logic       o_p2_attacking,
  output logic       o_game_over,
  output logic [1:0] o_winner
);
  localparam int TW = $clog2(TICK_DIV);
  logic [TW-1:0] r_cnt;
  logic [9:0] r_p1_x, r_p2_x, w_px1, w_px2, w_y1, w_y2;
  logic [7:0] r_p1_hp, r_p1_sh, r_p2_hp, r_p2_sh, w_p1_hp_nx, w_p1_sh_nx, w_p2_hp_nx, w_p2_sh_nx;
  logic r_go;
  logic [1:0] r_win;
  logic w_tick, w_restart, w_step, w_fire1, w_fire2, w_ok1, w_ok2, w_both, w_hit1, w_hit2, w_sh1, w_sh2;
  logic w_unused;
  function automatic logic ov(input logic [9:0] ax, ay, bx, by);
    return (int'(ax) < int'(bx) + CHAR_W) && (int'(bx) < int'(ax) + CHAR_W) &&
           (int'(ay) < int'(by) + CHAR_H) && (int'(by) < int'(ay) + CHAR_H);
  endfunction
  function automatic logic in_reach(input logic [9:0] ax, ay, bx, by);
    int g;
    g = (ax <= bx) ? int'(bx) - int'(ax) - CHAR_W : int'(ax) - int'(bx) - CHAR_W;
    return (g <= REACH) && (int'(ay) < int'(by) + CHAR_H) && (int'(by) < int'(ay) + CHAR_H);
  endfunction
  function automatic logic [7:0] sub_sat(input logic [7:0] v);
    return int'(v) > ATK_DMG ? v - 8'(ATK_DMG) : 8'd0;
  endfunction
  assign w_unused = i_p1_inputs[IN_DOWN] | i_p2_inputs[IN_DOWN];
  assign w_tick = r_cnt == TW'(TICK_DIV - 1);
  assign w_restart = w_tick & (i_p1_inputs[IN_CENTER] | i_p2_inputs[IN_CENTER]);
  assign w_step = w_tick & ~r_go & ~w_restart;
  fighter_motion #(.SCREEN_W(SCREEN_W), .CHAR_W(CHAR_W), .GROUND_Y(GROUND_Y), .STEP(STEP),
                   .JUMP_H(JUMP_H), .ATK_COOLDOWN(ATK_COOLDOWN)) u_p1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_step(w_step), .i_restart(w_restart),
    .i_left(i_p1_inputs[IN_LEFT]), .i_right(i_p1_inputs[IN_RIGHT]), .i_up(i_p1_inputs[IN_UP]),
    .i_atk(i_p1_inputs[IN_ATK]), .i_x(r_p1_x), .o_px(w_px1), .o_y(w_y1), .o_fire(w_fire1),
    .o_attacking(o_p1_attacking));
  fighter_motion #(.SCREEN_W(SCREEN_W), .CHAR_W(CHAR_W), .GROUND_Y(GROUND_Y), .STEP(STEP),
                   .JUMP_H(JUMP_H), .ATK_COOLDOWN(ATK_COOLDOWN)) u_p2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_step(w_step), .i_restart(w_restart),
    .i_left(i_p2_inputs[IN_LEFT]), .i_right(i_p2_inputs[IN_RIGHT]), .i_up(i_p2_inputs[IN_UP]),
    .i_atk(i_p2_inputs[IN_ATK]), .i_x(r_p2_x), .o_px(w_px2), .o_y(w_y2), .o_fire(w_fire2),
    .o_attacking(o_p2_attacking));
  // Each move is checked against the opponent's current box, then both proposals against each other.
  assign w_ok1 = (w_px1 != r_p1_x) && !ov(w_px1, w_y1, r_p2_x, w_y2);
  assign w_ok2 = (w_px2 != r_p2_x) && !ov(w_px2, w_y2, r_p1_x, w_y1);
  assign w_both = w_ok1 && w_ok2 && ov(w_px1, w_y1, w_px2, w_y2);
  assign w_hit2 = w_fire1 && in_reach(r_p1_x, w_y1, r_p2_x, w_y2);
  assign w_hit1 = w_fire2 && in_reach(r_p1_x, w_y1, r_p2_x, w_y2);
  assign w_sh1 = i_p1_inputs[IN_SHIELD] && r_p1_sh != '0;
  assign w_sh2 = i_p2_inputs[IN_SHIELD] && r_p2_sh != '0;
  assign w_p1_sh_nx = (w_hit1 && w_sh1) ? r_p1_sh - 1'b1 : r_p1_sh;
  assign w_p2_sh_nx = (w_hit2 && w_sh2) ? r_p2_sh - 1'b1 : r_p2_sh;
  assign w_p1_hp_nx = (w_hit1 && !w_sh1) ? sub_sat(r_p1_hp) : r_p1_hp;
  assign w_p2_hp_nx = (w_hit2 && !w_sh2) ? sub_sat(r_p2_hp) : r_p2_hp;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_p1_x <= 10'(P1_START_X);
      r_p2_x <= 10'(P2_START_X);
      r_p1_hp <= 8'(MAX_HEALTH);
      r_p2_hp <= 8'(MAX_HEALTH);
      r_p1_sh <= 8'(MAX_SHIELD);
      r_p2_sh <= 8'(MAX_SHIELD);
      r_go <= 1'b0;
      r_win <= WIN_NONE;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_restart) begin
        r_p1_x <= 10'(P1_START_X);
        r_p2_x <= 10'(P2_START_X);
        r_p1_hp <= 8'(MAX_HEALTH);
        r_p2_hp <= 8'(MAX_HEALTH);
        r_p1_sh <= 8'(MAX_SHIELD);
        r_p2_sh <= 8'(MAX_SHIELD);
        r_go <= 1'b0;
        r_win <= WIN_NONE;
      end else if (w_step) begin
        if (w_ok1 && !w_both) r_p1_x <= w_px1;
        if (w_ok2 && !w_both) r_p2_x <= w_px2;
        r_p1_hp <= w_p1_hp_nx;
        r_p2_hp <= w_p2_hp_nx;
        r_p1_sh <= w_p1_sh_nx;
        r_p2_sh <= w_p2_sh_nx;
        r_go <= w_p1_hp_nx == '0 || w_p2_hp_nx == '0;
        // Bit 1 flags p1 knocked out, bit 0 flags p2, giving 01/10/11 directly.
        r_win <= {w_p1_hp_nx == '0, w_p2_hp_nx == '0};
      end
    end
  end
  assign o_p1_x = r_p1_x;
  assign o_p2_x = r_p2_x;
  assign o_p1_y = w_y1;
  assign o_p2_y = w_y2;
  assign o_p1_health = r_p1_hp;
  assign o_p2_health = r_p2_hp;
  assign o_p1_shield = r_p1_sh;
  assign o_p2_shield = r_p2_sh;
  assign o_game_over = r_go;
  assign o_winner = r_win;
endmodule

// File: tb/tb_fight_arena_core.sv
// tb_fight_arena_core: directed stimulus with a tick-level behavioural arena model checked every cycle.
module tb_fight_arena_core;
  localparam int TD = 4;
  localparam logic [6:0] C = 7'h01, L = 7'h02, R = 7'h04, U = 7'h08, A = 7'h20, S = 7'h40;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] in1 = '0, in2 = '0;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic [7:0] p1_health, p1_shield, p2_health, p2_shield;
  logic p1_attacking, p2_attacking, game_over;
  logic [1:0] winner;
  int tests = 0, fails = 0;
  int mx[2], my[2], jp[2], cd[2], prv[2], hp[2], sh[2], go, win, mc = 0, tick_no = 0;
  always #5 clk = ~clk;
  fight_arena_core #(.TICK_DIV(TD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_p1_inputs(in1), .i_p2_inputs(in2),
    .o_p1_x(p1_x), .o_p1_y(p1_y), .o_p2_x(p2_x), .o_p2_y(p2_y),
    .o_p1_health(p1_health), .o_p1_shield(p1_shield), .o_p2_health(p2_health), .o_p2_shield(p2_shield),
    .o_p1_attacking(p1_attacking), .o_p2_attacking(p2_attacking), .o_game_over(game_over), .o_winner(winner));
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit boxes(input int ax, ay, bx, by);
    return ax < bx + 128 && bx < ax + 128 && ay < by + 128 && by < ay + 128;
  endfunction
  function automatic bit reach(input int ax, ay, bx, by);
    int g;
    g = (ax <= bx) ? bx - ax - 128 : ax - bx - 128;
    return g <= 16 && ay < by + 128 && by < ay + 128;
  endfunction
  task automatic m_reset();
    mx[0] = 200; mx[1] = 600;
    for (int p = 0; p < 2; p++) begin
      my[p] = 300; jp[p] = -1; cd[p] = 0; prv[p] = 0; hp[p] = 15; sh[p] = 15;
    end
    go = 0; win = 0;
  endtask
  // One game tick: jumps are a 192-tick arc, y derived from ticks elapsed since take-off.
  task automatic m_tick();
    int px[2];
    bit ok[2], hit[2], fire;
    logic [6:0] ip;
    if (in1[0] || in2[0]) begin m_reset(); return; end
    if (go != 0) return;
    for (int p = 0; p < 2; p++) begin
      ip = (p == 0) ? in1 : in2;
      px[p] = ip[1] ? (mx[p] > 0 ? mx[p] - 1 : 0) : ip[2] ? (mx[p] < 896 ? mx[p] + 1 : 896) : mx[p];
      ok[p] = px[p] != mx[p] && !boxes(px[p], my[p], mx[1-p], my[1-p]);
      fire = ip[5] && prv[p] == 0 && cd[p] == 0;
      hit[p] = fire && reach(mx[0], my[0], mx[1], my[1]);
      cd[p] = fire ? 20 : (cd[p] > 0 ? cd[p] - 1 : 0);
      prv[p] = ip[5];
    end
    if (ok[0] && ok[1] && boxes(px[0], my[0], px[1], my[1])) begin ok[0] = 0; ok[1] = 0; end
    for (int p = 0; p < 2; p++) begin
      ip = (p == 0) ? in1 : in2;
      if (ok[p]) mx[p] = px[p];
      if (jp[p] < 0) begin
        if (ip[3]) jp[p] = 0;
      end else begin
        jp[p]++;
        if (jp[p] == 192) jp[p] = -1;
      end
      my[p] = 300 - (jp[p] < 0 ? 0 : (jp[p] <= 96 ? jp[p] : 192 - jp[p]));
      if (hit[1-p]) begin
        if (ip[6] && sh[p] > 0) sh[p]--;
        else hp[p] = hp[p] > 3 ? hp[p] - 3 : 0;
      end
    end
    go = (hp[0] == 0 || hp[1] == 0) ? 1 : 0;
    win = (hp[0] == 0 ? 2 : 0) + (hp[1] == 0 ? 1 : 0);
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
      mc = 0;
    end else if (mc != TD - 1) mc++;
    else begin
      mc = 0;
      tick_no++;
      m_tick();
    end
  end
  always @(negedge clk) begin
    chk("p1_x", int'(p1_x), mx[0]);
    chk("p2_x", int'(p2_x), mx[1]);
    chk("p1_y", int'(p1_y), my[0]);
    chk("p2_y", int'(p2_y), my[1]);
    chk("p1_health", int'(p1_health), hp[0]);
    chk("p2_health", int'(p2_health), hp[1]);
    chk("p1_shield", int'(p1_shield), sh[0]);
    chk("p2_shield", int'(p2_shield), sh[1]);
    chk("p1_attacking", int'(p1_attacking), cd[0] != 0 ? 1 : 0);
    chk("p2_attacking", int'(p2_attacking), cd[1] != 0 ? 1 : 0);
    chk("game_over", int'(game_over), go);
    chk("winner", int'(winner), win);
  end
  task automatic run_ticks(input int n);
    int t;
    t = tick_no + n;
    while (tick_no < t) @(posedge clk);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p1_x", int'(p1_x), 200);
    chk("rst_p2_x", int'(p2_x), 600);
    chk("rst_y", int'(p1_y), 300);
    chk("rst_health", int'(p2_health), 15);
    chk("rst_shield", int'(p1_shield), 15);
    chk("rst_winner", int'(winner), 0);
    in1 = R;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("pre_first_tick", int'(p1_x), 200);
    @(posedge clk);
    #1 chk("first_tick", int'(p1_x), 201);
    run_ticks(271);
    chk("walk_stop", int'(p1_x), 472);
    run_ticks(5);
    chk("walk_blocked", int'(p1_x), 472);
    in1 = C; run_ticks(1); in1 = L;
    chk("center_x", int'(p1_x), 200);
    run_ticks(205);
    chk("left_wall", int'(p1_x), 0);
    in1 = C; run_ticks(1);
    in1 = R; run_ticks(1);
    in2 = L; run_ticks(140);
    chk("simul_p1", int'(p1_x), 336);
    chk("simul_p2", int'(p2_x), 465);
    in1 = C; in2 = 0; run_ticks(1);
    in1 = U; run_ticks(1);
    in1 = 0; run_ticks(96);
    chk("jump_apex", int'(p1_y), 204);
    in1 = U; run_ticks(10);
    in1 = 0; run_ticks(86);
    chk("jump_land", int'(p1_y), 300);
    run_ticks(5);
    chk("jump_no_rejump", int'(p1_y), 300);
    in1 = R; run_ticks(272);
    in1 = A; run_ticks(1);
    in1 = 0;
    chk("hit_health", int'(p2_health), 12);
    chk("atk_high", int'(p1_attacking), 1);
    run_ticks(4);
    in1 = A; run_ticks(1);
    in1 = 0; run_ticks(14);
    chk("cooldown_no_dmg", int'(p2_health), 12);
    chk("atk_still_high", int'(p1_attacking), 1);
    run_ticks(1);
    chk("atk_low", int'(p1_attacking), 0);
    in2 = S;
    for (int i = 0; i < 5; i++) begin
      in1 = A; run_ticks(1);
      in1 = 0; run_ticks(20);
    end
    chk("shield_left", int'(p2_shield), 10);
    chk("shield_health", int'(p2_health), 12);
    in2 = A; run_ticks(1);
    in2 = 0; run_ticks(20);
    chk("p2_hits_p1", int'(p1_health), 12);
    for (int i = 0; i < 3; i++) begin
      in1 = A; in2 = A; run_ticks(1);
      in1 = 0; in2 = 0; run_ticks(20);
    end
    chk("pre_draw_p1", int'(p1_health), 3);
    chk("pre_draw_p2", int'(p2_health), 3);
    in1 = A; in2 = A; run_ticks(1);
    in1 = 0; in2 = 0;
    chk("draw_p1", int'(p1_health), 0);
    chk("draw_go", int'(game_over), 1);
    chk("draw_winner", int'(winner), 3);
    in2 = R | U; run_ticks(5);
    chk("frozen_x", int'(p2_x), 600);
    chk("frozen_y", int'(p2_y), 300);
    in2 = C; run_ticks(1);
    in2 = 0;
    chk("restart_go", int'(game_over), 0);
    chk("restart_winner", int'(winner), 0);
    chk("restart_health", int'(p1_health), 15);
    chk("restart_p1_x", int'(p1_x), 200);
    run_ticks(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
